// File: rtl/trng_collector.sv
// Serial TRNG bit collector: warm-up discard, repetition-count and adaptive-proportion
// health tests, LSB-first word packing into a one-entry output buffer, sticky alarm/overflow.
module trng_collector #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned WARMUP_BITS = 64,
    parameter int unsigned RCT_CUTOFF  = 21,
    parameter int unsigned APT_WINDOW  = 1024,
    parameter int unsigned APT_CUTOFF  = 589
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic             o_data_valid,
    input  logic             i_data_ready,
    output logic             o_alarm,
    output logic             o_overflow
);

    localparam int unsigned WARM_W = $clog2(WARMUP_BITS + 1);
    localparam int unsigned PACK_W = $clog2(WIDTH + 1);
    localparam int unsigned RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned APTC_W = $clog2(APT_CUTOFF + 1);
    localparam int unsigned APTI_W = $clog2(APT_WINDOW + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_BITS - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARMUP_BITS);
    localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(WIDTH - 1);
    localparam logic [PACK_W-1:0] PACK_FULL = PACK_W'(WIDTH);
    localparam logic [RCT_W-1:0]  RCT_MAX   = RCT_W'(RCT_CUTOFF);
    localparam logic [APTC_W-1:0] APTC_MAX  = APTC_W'(APT_CUTOFF);
    localparam logic [APTI_W-1:0] APT_LAST  = APTI_W'(APT_WINDOW - 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_ALARM  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [WIDTH-1:0]    pack_q, pack_d;
    logic [PACK_W-1:0]   pack_cnt_q, pack_cnt_d;
    logic [WIDTH-1:0]    buf_q, buf_d;
    logic                buf_vld_q, buf_vld_d;
    logic [RCT_W-1:0]    rct_q, rct_d;
    logic                prev_q, prev_d;
    logic [APTC_W-1:0]   apt_cnt_q, apt_cnt_d;
    logic [APTI_W-1:0]   apt_idx_q, apt_idx_d;
    logic                apt_ref_q, apt_ref_d;
    logic                alarm_q, alarm_d;
    logic                ovf_q, ovf_d;

    logic [RCT_W-1:0]    rct_new;
    logic [APTC_W-1:0]   apt_cnt_new;
    logic [APTI_W-1:0]   apt_idx_new;
    logic                apt_ref_new;
    logic                bit_ok;
    logic                fail;
    logic                pop;
    logic                can_load;
    logic [WIDTH-1:0]    shifted;

    // Candidate health-test counter values if the current bit is accepted
    always_comb begin
        rct_new     = RCT_W'(1);
        apt_ref_new = apt_ref_q;
        apt_cnt_new = apt_cnt_q;
        apt_idx_new = apt_idx_q + APTI_W'(1);
        if (rct_q != '0 && i_bit == prev_q) begin
            rct_new = (rct_q == RCT_MAX) ? rct_q : rct_q + RCT_W'(1);
        end
        if (apt_idx_q == '0) begin
            apt_ref_new = i_bit;
            apt_cnt_new = APTC_W'(1);
        end else if (i_bit == apt_ref_q && apt_cnt_q != APTC_MAX) begin
            apt_cnt_new = apt_cnt_q + APTC_W'(1);
        end
        if (apt_idx_q == APT_LAST) begin
            apt_idx_new = '0;
        end
    end

    assign bit_ok   = i_valid && (state_q != ST_ALARM);
    assign fail     = bit_ok && ((rct_new >= RCT_MAX) || (apt_cnt_new >= APTC_MAX));
    assign pop      = buf_vld_q && i_data_ready;
    assign can_load = !buf_vld_q || pop;
    assign shifted  = {i_bit, pack_q[WIDTH-1:1]};

    // Next-state and datapath; clear beats failure, failure beats normal operation
    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        pack_d     = pack_q;
        pack_cnt_d = pack_cnt_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        rct_d      = rct_q;
        prev_d     = prev_q;
        apt_cnt_d  = apt_cnt_q;
        apt_idx_d  = apt_idx_q;
        apt_ref_d  = apt_ref_q;
        alarm_d    = alarm_q;
        ovf_d      = ovf_q;

        if (i_clear) begin
            state_d    = ST_WARMUP;
            warm_d     = '0;
            pack_d     = '0;
            pack_cnt_d = '0;
            buf_vld_d  = 1'b0;
            rct_d      = '0;
            prev_d     = 1'b0;
            apt_cnt_d  = '0;
            apt_idx_d  = '0;
            apt_ref_d  = 1'b0;
            alarm_d    = 1'b0;
            ovf_d      = 1'b0;
        end else if (fail) begin
            state_d    = ST_ALARM;
            alarm_d    = 1'b1;
            buf_d      = '0;
            buf_vld_d  = 1'b0;
            pack_d     = '0;
            pack_cnt_d = '0;
        end else begin
            if (bit_ok) begin
                rct_d     = rct_new;
                prev_d    = i_bit;
                apt_cnt_d = apt_cnt_new;
                apt_idx_d = apt_idx_new;
                apt_ref_d = apt_ref_new;
            end
            if (pop) begin
                buf_vld_d = 1'b0;
            end
            case (state_q)
                ST_WARMUP: begin
                    if (i_valid) begin
                        if (warm_q == WARM_LAST) begin
                            warm_d  = WARM_DONE;
                            state_d = ST_RUN;
                        end else begin
                            warm_d = warm_q + WARM_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (pack_cnt_q == PACK_FULL) begin
                        // Stalled full word drains as soon as the buffer frees up
                        if (can_load) begin
                            buf_d      = pack_q;
                            buf_vld_d  = 1'b1;
                            pack_cnt_d = i_valid ? PACK_W'(1) : '0;
                            if (i_valid) begin
                                pack_d = shifted;
                            end
                        end else if (i_valid) begin
                            ovf_d = 1'b1;
                        end
                    end else if (i_valid) begin
                        pack_d = shifted;
                        if (pack_cnt_q == PACK_LAST) begin
                            if (can_load) begin
                                buf_d      = shifted;
                                buf_vld_d  = 1'b1;
                                pack_cnt_d = '0;
                            end else begin
                                pack_cnt_d = PACK_FULL;
                            end
                        end else begin
                            pack_cnt_d = pack_cnt_q + PACK_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_WARMUP;
            warm_q     <= '0;
            pack_q     <= '0;
            pack_cnt_q <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            rct_q      <= '0;
            prev_q     <= 1'b0;
            apt_cnt_q  <= '0;
            apt_idx_q  <= '0;
            apt_ref_q  <= 1'b0;
            alarm_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            pack_q     <= pack_d;
            pack_cnt_q <= pack_cnt_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            rct_q      <= rct_d;
            prev_q     <= prev_d;
            apt_cnt_q  <= apt_cnt_d;
            apt_idx_q  <= apt_idx_d;
            apt_ref_q  <= apt_ref_d;
            alarm_q    <= alarm_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_data       = buf_q;
    assign o_data_valid = buf_vld_q;
    assign o_alarm      = alarm_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_trng_collector.sv
// Self-checking bench for trng_collector: directed scenarios plus a randomized stream,
// scored against a queue-based behavioural model of the collector.
module tb_trng_collector;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned WARM  = 64;
    localparam int unsigned RCT   = 21;
    localparam int unsigned APTW  = 1024;
    localparam int unsigned APTC  = 589;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid, i_bit, i_clear, i_data_ready;
    logic [WIDTH-1:0]  o_data;
    logic              o_data_valid, o_alarm, o_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    trng_collector #(
        .WIDTH(WIDTH), .WARMUP_BITS(WARM), .RCT_CUTOFF(RCT),
        .APT_WINDOW(APTW), .APT_CUTOFF(APTC)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_bit(i_bit), .i_clear(i_clear),
        .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .o_alarm(o_alarm), .o_overflow(o_overflow)
    );

    // Behavioural model: phase 0 warm-up, 1 run, 2 alarm; packer is a bit queue
    int               m_phase, m_warm, m_run, m_pos, m_match;
    bit               m_prev, m_ref, m_buf_valid, m_alarm, m_ovf;
    bit               m_pack[$];
    logic [WIDTH-1:0] m_buf;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];

    function automatic logic [WIDTH-1:0] pack_word();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < int'(WIDTH); i++) w[i] = m_pack[i];
        return w;
    endfunction

    function automatic void model_clear();
        m_phase = 0; m_warm = 0; m_run = 0; m_pos = 0; m_match = 0;
        m_prev = 0; m_ref = 0; m_buf_valid = 0; m_alarm = 0; m_ovf = 0;
        m_buf = '0;
        m_pack.delete();
    endfunction

    function automatic void model_step(bit v, bit b, bit rdy, bit clr);
        bit pop  = m_buf_valid && rdy;
        bit fail = 0;
        if (pop) exp_q.push_back(m_buf);
        if (clr) begin model_clear(); return; end
        if (m_phase == 2) return;
        if (v) begin
            m_run  = (m_run > 0 && b == m_prev) ? m_run + 1 : 1;
            m_prev = b;
            if (m_run >= int'(RCT)) fail = 1;
            if (m_pos == 0) begin m_ref = b; m_match = 1; end
            else if (b == m_ref) m_match++;
            m_pos = (m_pos + 1) % int'(APTW);
            if (m_match >= int'(APTC)) fail = 1;
        end
        if (fail) begin
            m_phase = 2; m_alarm = 1; m_buf_valid = 0; m_buf = '0; m_pack.delete();
            return;
        end
        if (pop) m_buf_valid = 0;
        if (m_phase == 0) begin
            if (v) begin m_warm++; if (m_warm == int'(WARM)) m_phase = 1; end
        end else begin
            if (m_pack.size() == int'(WIDTH) && !m_buf_valid) begin
                m_buf = pack_word(); m_buf_valid = 1; m_pack.delete();
            end
            if (v) begin
                if (m_pack.size() == int'(WIDTH)) m_ovf = 1;
                else begin
                    m_pack.push_back(b);
                    if (m_pack.size() == int'(WIDTH) && !m_buf_valid) begin
                        m_buf = pack_word(); m_buf_valid = 1; m_pack.delete();
                    end
                end
            end
        end
    endfunction

    // One clock: drive inputs, log a DUT handshake, advance the model, sample #1 after edge
    task automatic step(bit v, bit b, bit rdy, bit clr);
        i_valid = v; i_bit = b; i_data_ready = rdy; i_clear = clr;
        if (o_data_valid && rdy) got_q.push_back(o_data);
        model_step(v, b, rdy, clr);
        @(posedge clk); #1;
    endtask

    task automatic warm_alt(bit first, bit rdy);
        for (int i = 0; i < int'(WARM); i++) step(1'b1, first ^ i[0], rdy, 1'b0);
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 1'b1, 1'b1);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; i_valid = 0; i_bit = 0; i_clear = 0; i_data_ready = 0;
        #12;
        tests_run++; if (o_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h exp 0", o_data); end
        tests_run++; if (o_data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", o_data_valid); end
        tests_run++; if (o_alarm !== 1'b0) begin tests_failed++; $display("FAIL reset_alarm: got %b exp 0", o_alarm); end
        tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b exp 0", o_overflow); end
        @(negedge clk); rst = 1'b1;
        model_clear(); got_q.delete(); exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_warmup_pack();
        logic [WIDTH-1:0] p = 32'hA5A5_00FF;
        warm_alt(1'b0, 1'b1);
        for (int i = 0; i < int'(WIDTH); i++) begin
            step(1'b1, p[i], 1'b1, 1'b0);
            if (i == int'(WIDTH) - 2) begin
                tests_run++; if (o_data_valid !== 1'b0) begin tests_failed++; $display("FAIL pack_early_valid: got %b exp 0", o_data_valid); end
            end
        end
        tests_run++; if (o_data_valid !== 1'b1) begin tests_failed++; $display("FAIL pack_valid: got %b exp 1", o_data_valid); end
        tests_run++; if (o_data !== p) begin tests_failed++; $display("FAIL pack_data: got %h exp %h", o_data, p); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (got_q.size() != 1 || got_q[0] !== p) begin tests_failed++; $display("FAIL pack_words: got %0d words first %h exp 1 word %h", got_q.size(), got_q.size() > 0 ? got_q[0] : '0, p); end
        tests_run++; if (o_data_valid !== 1'b0) begin tests_failed++; $display("FAIL pack_pop: got %b exp 0", o_data_valid); end
    endtask

    task automatic test_rct();
        restart();
        warm_alt(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tests_run++; if (o_alarm !== 1'b0) begin tests_failed++; $display("FAIL rct_20_alarm: got %b exp 0", o_alarm); end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++; if (o_alarm !== 1'b0 || o_data_valid !== 1'b1) begin tests_failed++; $display("FAIL rct_pre: got alarm %b valid %b exp 0 1", o_alarm, o_data_valid); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++; if (o_alarm !== 1'b1) begin tests_failed++; $display("FAIL rct_21_alarm: got %b exp 1", o_alarm); end
        tests_run++; if (o_data_valid !== 1'b0) begin tests_failed++; $display("FAIL rct_discard: got %b exp 0", o_data_valid); end
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                step(1'b1, 1'($urandom), 1'b1, 1'b0);
                if (o_data_valid || !o_alarm) seen++;
            end
            tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL alarm_hold: got %0d bad cycles exp 0", seen); end
        end
    endtask

    task automatic test_apt();
        for (int k = 588; k <= 589; k++) begin
            int mism = 0;
            restart();
            for (int i = 0; i < int'(APTW); i++) begin
                step(1'b1, ((i * k) % int'(APTW)) < k, 1'b1, 1'b0);
                if (o_alarm !== m_alarm) mism++;
            end
            step(1'b0, 1'b0, 1'b1, 1'b0);
            tests_run++; if (o_alarm !== (k == 589)) begin tests_failed++; $display("FAIL apt_%0d_alarm: got %b exp %b", k, o_alarm, k == 589); end
            tests_run++; if (mism != 0) begin tests_failed++; $display("FAIL apt_%0d_timing: got %0d mismatching cycles exp 0", k, mism); end
            tests_run++; if (got_q != exp_q) begin tests_failed++; $display("FAIL apt_%0d_words: got %0d words exp %0d", k, got_q.size(), exp_q.size()); end
        end
    endtask

    task automatic test_backpressure();
        bit               bp[70];
        logic [WIDTH-1:0] w1, w2, held;
        int               n = 0, unstable = 0;
        bit               have = 0;
        restart();
        for (int i = 0; i < int'(WARM); i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
        for (int c = 0; c < 1000 && n < 70; c++) begin
            bit v = ($urandom % 4) != 0;
            bit b = 1'($urandom);
            step(v, b, 1'b0, 1'b0);
            if (v) begin bp[n] = b; n++; end
            if (have && (o_data !== held || o_data_valid !== 1'b1)) unstable++;
            if (!have && n >= int'(WIDTH)) begin held = o_data; have = 1; end
        end
        for (int i = 0; i < int'(WIDTH); i++) begin w1[i] = bp[i]; w2[i] = bp[WIDTH + i]; end
        tests_run++; if (n != 70) begin tests_failed++; $display("FAIL bp_budget: got %0d bits exp 70", n); end
        tests_run++; if (held !== w1) begin tests_failed++; $display("FAIL bp_first: got %h exp %h", held, w1); end
        tests_run++; if (unstable != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d changes exp 0", unstable); end
        tests_run++; if (o_overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_overflow: got %b exp 1", o_overflow); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (got_q.size() != 2 || got_q[0] !== w1 || got_q[1] !== w2) begin tests_failed++; $display("FAIL bp_order: got %0d words exp %h %h", got_q.size(), w1, w2); end
        tests_run++; if (got_q != exp_q) begin tests_failed++; $display("FAIL bp_model: got %0d words exp %0d", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_clear_vs_fail();
        int seen = 0;
        restart();
        warm_alt(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        tests_run++; if (o_alarm !== 1'b0) begin tests_failed++; $display("FAIL clr_alarm: got %b exp 0", o_alarm); end
        tests_run++; if (o_data_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_valid: got %b exp 0", o_data_valid); end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, i[0], 1'b1, 1'b0);
            if (o_data_valid !== 1'b0 || o_alarm !== 1'b0) seen++;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL clr_warmup: got %0d active cycles exp 0", seen); end
    endtask

    task automatic test_reset_mid();
        bit               rb[96];
        logic [WIDTH-1:0] w = '0;
        restart();
        for (int i = 0; i < int'(WARM) + 42; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        tests_run++; if (o_data_valid !== 1'b1) begin tests_failed++; $display("FAIL rstm_pre: got %b exp 1", o_data_valid); end
        #2 rst = 1'b0;
        #1;
        tests_run++; if ({o_data_valid, o_alarm, o_overflow} !== 3'b000 || o_data !== '0) begin tests_failed++; $display("FAIL rstm_async: got v%b a%b o%b d%h exp all 0", o_data_valid, o_alarm, o_overflow, o_data); end
        i_valid = 0; i_clear = 0;
        @(negedge clk); rst = 1'b1;
        model_clear(); got_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 96; i++) begin
            rb[i] = 1'($urandom);
            step(1'b1, rb[i], 1'b0, 1'b0);
            if (i == 94) begin
                tests_run++; if (o_data_valid !== 1'b0) begin tests_failed++; $display("FAIL rstm_warm: got %b exp 0", o_data_valid); end
            end
        end
        for (int i = 0; i < int'(WIDTH); i++) w[i] = rb[WARM + i];
        tests_run++; if (o_data_valid !== 1'b1 || o_data !== w) begin tests_failed++; $display("FAIL rstm_word: got v%b %h exp v1 %h", o_data_valid, o_data, w); end
    endtask

    task automatic test_random_stream();
        int mism = 0;
        restart();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 3) != 0, 1'($urandom), ($urandom % 4) != 0, ($urandom % 1000) == 0);
            if (o_data_valid !== m_buf_valid || o_alarm !== m_alarm || o_overflow !== m_ovf ||
                (m_buf_valid && o_data !== m_buf)) mism++;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (mism != 0) begin tests_failed++; $display("FAIL rand_cycles: got %0d mismatching cycles exp 0", mism); end
        tests_run++; if (got_q != exp_q) begin tests_failed++; $display("FAIL rand_words: got %0d words exp %0d", got_q.size(), exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_warmup_pack();
        test_rct();
        test_apt();
        test_backpressure();
        test_clear_vs_fail();
        test_reset_mid();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
